fft_symbol_buffer: RTL
======================

FFT_SYMBOL_BUFFER -- requirements
Module: fft_symbol_buffer

Interface
REQ-001 Parameter fft_depth, default 12, sample component width in bits.
REQ-002 Parameter fftsize, default 1024, samples per symbol (power of two).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 isop  input  1  first sample of a CP-stripped symbol; qualified by ival.
REQ-006 ival  input  1  input sample valid.
REQ-007 in_real_data / in_imag_data  input  fft_depth each  I/Q sample.
REQ-008 count_frame  input  7  symbol index from the CP-removal stage; sampled with isop.
REQ-009 iready  input  1  FFT sink ready.
REQ-010 osop / oeop  output  1 each  first / last sample of the output symbol.
REQ-011 oval  output  1  output sample valid.
REQ-012 out_real_data / out_imag_data  output  fft_depth each  output I/Q sample.
REQ-013 out_symb_idx  output  7  count_frame captured for the symbol being read.
REQ-014 overflow / short_symb  output  1 each  single-cycle error pulses.

Function
REQ-015 Storage: two banks (ping-pong), each fftsize x (2*fft_depth), one full flag per bank.
REQ-016 Write FSM states: W_IDLE, W_FILL.
REQ-017 W_IDLE: ival & ~isop samples discarded; ival & isop with target bank not full -> write sample at address 0, capture count_frame, go W_FILL.
REQ-018 W_IDLE: ival & isop with target bank full -> symbol dropped, overflow pulses next cycle, remain W_IDLE.
REQ-019 W_FILL: each ival sample writes at next address; ival low stalls without state change.
REQ-020 W_FILL: sample written at address fftsize-1 sets the bank full flag, toggles target bank, returns to W_IDLE.
REQ-021 W_FILL: ival & isop before address fftsize-1 -> short_symb pulses, write restarts at address 0 of the same bank, count_frame recaptured.
REQ-022 Read FSM states: R_IDLE, R_STREAM.
REQ-023 R_IDLE with read bank full -> R_STREAM; first oval no later than 2 cycles after the full flag sets.
REQ-024 R_STREAM outputs addresses 0..fftsize-1 of the read bank in natural order; one sample advances per cycle where oval & iready.
REQ-025 oval & ~iready: data, osop, oeop, out_symb_idx held stable; no sample lost or duplicated (RAM latency hidden by a skid/output register).
REQ-026 osop asserted with address 0, oeop with address fftsize-1, both only while oval.
REQ-027 Acceptance of address fftsize-1 clears the bank full flag in that cycle, toggles read bank, returns to R_IDLE; other bank already full -> streaming resumes with no more than 2 idle cycles.
REQ-028 Full flag set (write) and cleared (read) in the same cycle on different banks both take effect; the freed bank is writable from the next cycle.
REQ-029 Sustained throughput: ival continuously high and iready continuously high -> no overflow.
REQ-030 out_real_data / out_imag_data driven to 0 whenever oval is low.

Reset
REQ-031 rst low asynchronously forces: both FSMs idle, both full flags 0, both bank pointers to bank 0, addresses 0, oval/osop/oeop/overflow/short_symb 0, out data 0, out_symb_idx 0.
REQ-032 Reset mid-symbol discards all partially written and unread data; after release first accepted input is the next ival & isop.
REQ-033 RAM contents need no reset.

Verification
REQ-034 fftsize=16; one symbol, samples I=n, Q=-n, count_frame=5, iready=1 -> 16 oval beats I=0..15, osop on beat 0, oeop on beat 15, out_symb_idx=5.
REQ-035 Three back-to-back symbols, iready toggled 1/0 each cycle -> 48 samples in order, no overflow, no duplicates.
REQ-036 iready=0 held; three symbols sent -> first two stored, third dropped, overflow pulses once; then iready=1 -> symbols 1 and 2 output intact.
REQ-037 isop re-asserted at sample 9 of a symbol -> short_symb pulses once; the restarted symbol is output with 16 samples, first sample = restart sample.
REQ-038 rst low during streaming of sample 7 -> oval=0 immediately; after release no output until a new isop symbol completes.
REQ-039 ival samples with no isop after reset -> no oval, no error pulses.

Source files
------------

// File: rtl/fft_symbol_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_symbol_buffer
// Purpose  : Ping-pong symbol buffer between CP removal and the FFT core.
//            Collects fftsize-sample symbols into one of two RAM banks and
//            streams each complete bank out in natural order under
//            valid/ready flow control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous reset, active low
//   isop / ival    in   start-of-symbol flag / sample valid
//   in_real_data   in   I sample (fft_depth bits)
//   in_imag_data   in   Q sample (fft_depth bits)
//   count_frame    in   symbol index, captured with isop
//   iready         in   FFT sink ready
//   osop / oeop    out  first / last sample of output symbol
//   oval           out  output sample valid
//   out_real_data  out  I sample (0 when oval low)
//   out_imag_data  out  Q sample (0 when oval low)
//   out_symb_idx   out  count_frame of the symbol being read
//   overflow       out  pulse: symbol dropped, target bank still full
//   short_symb     out  pulse: isop arrived before the symbol completed
// ============================================================================
module fft_symbol_buffer #(
  parameter int fft_depth = 12,
  parameter int fftsize   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 isop,
  input  logic                 ival,
  input  logic [fft_depth-1:0] in_real_data,
  input  logic [fft_depth-1:0] in_imag_data,
  input  logic [6:0]           count_frame,
  input  logic                 iready,
  output logic                 osop,
  output logic                 oeop,
  output logic                 oval,
  output logic [fft_depth-1:0] out_real_data,
  output logic [fft_depth-1:0] out_imag_data,
  output logic [6:0]           out_symb_idx,
  output logic                 overflow,
  output logic                 short_symb
);

  localparam int c_aw = $clog2(fftsize);
  localparam int c_dw = 2 * fft_depth;
  localparam logic [c_aw-1:0] c_last = c_aw'(fftsize - 1);

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_FILL   = 1'b1;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_STREAM = 1'b1;

  // Both banks share one array; the bank bit is the address MSB.
  logic [c_dw-1:0] r_mem [0:2*fftsize-1];

  // Write side
  logic [0:0]      r_wstate;
  logic            r_wbank;
  logic [c_aw-1:0] r_waddr;
  logic [1:0]      r_full;
  logic [6:0]      r_widx [2];
  logic            r_overflow;
  logic            r_short;

  // Read side: address FSM, RAM-output stage (p) and output register (o)
  logic [0:0]      r_rstate;
  logic            r_rbank;
  logic [c_aw-1:0] r_raddr;
  logic            r_p_valid;
  logic            r_p_sop;
  logic            r_p_eop;
  logic            r_p_bank;
  logic [6:0]      r_p_idx;
  logic [c_dw-1:0] r_p_data;
  logic            r_oval;
  logic            r_osop;
  logic            r_oeop;
  logic            r_obank;
  logic [6:0]      r_oidx;
  logic [c_dw-1:0] r_odata;

  logic            w_we;
  logic [c_aw-1:0] w_wa;
  logic            w_start;
  logic            w_fin;
  logic            w_ovf;
  logic            w_short;
  logic            w_out_load;
  logic            w_issue;
  logic [1:0]      w_set_mask;
  logic [1:0]      w_clr_mask;

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    w_we    = 1'b0;
    w_wa    = '0;
    w_start = 1'b0;
    w_fin   = 1'b0;
    w_ovf   = 1'b0;
    w_short = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (ival && isop) begin
          if (r_full[r_wbank]) begin
            w_ovf = 1'b1;
          end else begin
            w_we    = 1'b1;
            w_start = 1'b1;
          end
        end
      end
      default: begin
        if (ival) begin
          w_we = 1'b1;
          if (isop && (r_waddr != c_last)) begin
            // Restart the same bank from address 0 with the new sample.
            w_short = 1'b1;
            w_start = 1'b1;
          end else begin
            w_wa  = r_waddr;
            w_fin = (r_waddr == c_last);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate   <= W_IDLE;
      r_wbank    <= 1'b0;
      r_waddr    <= '0;
      r_widx[0]  <= '0;
      r_widx[1]  <= '0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
      r_short    <= w_short;
      if (w_start) begin
        r_waddr         <= c_aw'(1);
        r_widx[r_wbank] <= count_frame;
        r_wstate        <= W_FILL;
      end else if (w_fin) begin
        r_waddr  <= '0;
        r_wbank  <= ~r_wbank;
        r_wstate <= W_IDLE;
      end else if (w_we) begin
        r_waddr <= r_waddr + c_aw'(1);
      end
    end
  end

  // ------------------------------------------------------------- full flags
  // Set and clear always target different banks, so both apply together.
  assign w_set_mask = w_fin ? (2'b01 << r_wbank) : 2'b00;
  assign w_clr_mask = (r_oval && iready && r_oeop) ? (2'b01 << r_obank) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set_mask) & ~w_clr_mask;
    end
  end

  // ---------------------------------------------------------------- read side
  // A read is issued only when the RAM-output stage will be free next cycle,
  // so the two-deep pipeline acts as the skid buffer for the RAM latency.
  // The bank is released on acceptance of its last sample; the address FSM
  // may already be reading the other bank by then.
  assign w_out_load = ~r_oval | iready;
  assign w_issue    = ((r_rstate == R_STREAM) | r_full[r_rbank]) &
                      (~r_p_valid | w_out_load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_rbank   <= 1'b0;
      r_raddr   <= '0;
      r_p_valid <= 1'b0;
      r_p_sop   <= 1'b0;
      r_p_eop   <= 1'b0;
      r_p_bank  <= 1'b0;
      r_p_idx   <= '0;
    end else begin
      if (w_issue) begin
        r_p_valid <= 1'b1;
        r_p_sop   <= (r_raddr == '0);
        r_p_eop   <= (r_raddr == c_last);
        r_p_bank  <= r_rbank;
        r_p_idx   <= r_widx[r_rbank];
        if (r_raddr == c_last) begin
          r_raddr  <= '0;
          r_rbank  <= ~r_rbank;
          r_rstate <= R_IDLE;
        end else begin
          r_raddr  <= r_raddr + c_aw'(1);
          r_rstate <= R_STREAM;
        end
      end else if (w_out_load) begin
        r_p_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oval  <= 1'b0;
      r_osop  <= 1'b0;
      r_oeop  <= 1'b0;
      r_obank <= 1'b0;
      r_oidx  <= '0;
      r_odata <= '0;
    end else if (w_out_load) begin
      r_oval <= r_p_valid;
      if (r_p_valid) begin
        r_osop  <= r_p_sop;
        r_oeop  <= r_p_eop;
        r_obank <= r_p_bank;
        r_oidx  <= r_p_idx;
        r_odata <= r_p_data;
      end else begin
        r_osop  <= 1'b0;
        r_oeop  <= 1'b0;
        r_odata <= '0;
      end
    end
  end

  // ------------------------------------------------------------------ storage
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{r_wbank, w_wa}] <= {in_real_data, in_imag_data};
    end
    if (w_issue) begin
      r_p_data <= r_mem[{r_rbank, r_raddr}];
    end
  end

  assign oval          = r_oval;
  assign osop          = r_osop;
  assign oeop          = r_oeop;
  assign out_symb_idx  = r_oidx;
  assign out_real_data = r_odata[c_dw-1:fft_depth];
  assign out_imag_data = r_odata[fft_depth-1:0];
  assign overflow      = r_overflow;
  assign short_symb    = r_short;

endmodule
`default_nettype wire
